// File: rtl/somador_reg.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin with one cycle of latency,
// plus valid qualification and registered zero / signed-overflow flags.
// WIDTH=1 is the single-bit full adder used by the ADDAC datapath.
module somador_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid,
  output logic             zero,
  output logic             ovf
);

  // Carry chain: c[i] is the carry into bit i, c[WIDTH] is the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  // Bitwise ripple of full-adder cells.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  // Next state: capture on in_valid, otherwise hold the result and drop out_valid.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum;
      cout_d      = c[WIDTH];
      zero_d      = (sum == '0);
      // Signed overflow: carry into the MSB differs from the carry out of it.
      ovf_d       = c[WIDTH] ^ c[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  // Result registers with synchronous reset taking priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_somador_reg.sv
// Self-checking bench for somador_reg: one WIDTH=1 and one WIDTH=8 instance,
// expected results queued at stimulus time and compared one edge later.
module tb_somador_reg;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       zero;
    logic       ovf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic [0:0] s1;
  logic       cout1, out_valid1, zero1, ovf1;

  logic       in_valid8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic [7:0] s8;
  logic       cout8, out_valid8, zero8, ovf8;

  res_t o1, o8;
  res_t q1[$];
  res_t q8[$];
  res_t exp_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign o1 = {7'b0, s1, cout1, zero1, ovf1};
  assign o8 = {s8, cout8, zero8, ovf8};

  somador_reg #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .out_valid(out_valid1), .zero(zero1), .ovf(ovf1)
  );

  somador_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .out_valid(out_valid8), .zero(zero8), .ovf(ovf8)
  );

  // Reference model built from integer arithmetic, independent of the carry chain.
  function automatic res_t model(int w, logic [7:0] a, logic [7:0] b, logic cin);
    int   mask, u, sa, sb, t;
    res_t r;
    mask   = (1 << w) - 1;
    u      = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
    r.s    = 8'(u & mask);
    r.cout = ((u >> w) & 1) != 0;
    r.zero = (u & mask) == 0;
    sa     = int'(a) & mask;
    sb     = int'(b) & mask;
    if (sa >= (1 << (w - 1))) sa -= (1 << w);
    if (sb >= (1 << (w - 1))) sb -= (1 << w);
    t      = sa + sb + int'(cin);
    r.ovf  = (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 4;
      if (o1 !== res_t'(0)) begin
        failures++; $display("FAIL reset_w1_result: got %h expected %h", o1, res_t'(0));
      end
      if (out_valid1 !== 1'b0) begin
        failures++; $display("FAIL reset_w1_valid: got %b expected 0", out_valid1);
      end
      if (o8 !== res_t'(0)) begin
        failures++; $display("FAIL reset_w8_result: got %h expected %h", o8, res_t'(0));
      end
      if (out_valid8 !== 1'b0) begin
        failures++; $display("FAIL reset_w8_valid: got %b expected 0", out_valid8);
      end
    end
    // First result one edge after release.
    rst = 1'b0;
    q1.push_back(model(1, 8'(a1), 8'(b1), cin1));
    q8.push_back(model(8, a8, b8, cin8));
    tick();
    in_valid1 = 1'b0;
    in_valid8 = 1'b0;
    checks += 4;
    exp_r = q1.pop_front();
    if (o1 !== exp_r) begin
      failures++; $display("FAIL release_w1_result: got %h expected %h", o1, exp_r);
    end
    if (out_valid1 !== 1'b1) begin
      failures++; $display("FAIL release_w1_valid: got %b expected 1", out_valid1);
    end
    exp_r = q8.pop_front();
    if (o8 !== exp_r) begin
      failures++; $display("FAIL release_w8_result: got %h expected %h", o8, exp_r);
    end
    if (out_valid8 !== 1'b1) begin
      failures++; $display("FAIL release_w8_valid: got %b expected 1", out_valid8);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] tt[8];
    logic [2:0] v;
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      in_valid1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      q1.push_back(model(1, 8'(v[2]), 8'(v[1]), v[0]));
      tick();
      checks += 3;
      if ({s1, cout1} !== tt[i]) begin
        failures++; $display("FAIL truth_%0d_s_cout: got %b expected %b", i, {s1, cout1}, tt[i]);
      end
      if (q1.size() == 0) begin
        failures++; $display("FAIL truth_%0d_queue: got empty expected entry", i);
      end else begin
        exp_r = q1.pop_front();
        if (o1 !== exp_r) begin
          failures++; $display("FAIL truth_%0d_flags: got %h expected %h", i, o1, exp_r);
        end
      end
      if (out_valid1 !== 1'b1) begin
        failures++; $display("FAIL truth_%0d_valid: got %b expected 1", i, out_valid1);
      end
    end
    in_valid1 = 1'b0;
  endtask

  // Directed 8-bit wrap and signed-overflow vectors, issued back to back.
  task automatic test_wrap_ovf();
    logic [7:0] va[3];
    logic [7:0] vb[3];
    res_t       ve[3];
    va = '{8'hFF, 8'h7F, 8'h80};
    vb = '{8'h01, 8'h01, 8'h80};
    ve = '{{8'h00, 1'b1, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b1, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      in_valid8 = 1'b1; a8 = va[i]; b8 = vb[i]; cin8 = 1'b0;
      q8.push_back(ve[i]);
      tick();
      checks += 2;
      exp_r = q8.pop_front();
      if (o8 !== exp_r) begin
        failures++; $display("FAIL wrap_ovf_%0d: got %h expected %h", i, o8, exp_r);
      end
      if (out_valid8 !== 1'b1) begin
        failures++; $display("FAIL wrap_ovf_%0d_valid: got %b expected 1", i, out_valid8);
      end
    end
    in_valid8 = 1'b0;
  endtask

  task automatic test_valid_gating();
    res_t held;
    held = '{s: 8'h09, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    in_valid8 = 1'b1; a8 = 8'h05; b8 = 8'h03; cin8 = 1'b1;
    q8.push_back(held);
    tick();
    checks += 1;
    exp_r = q8.pop_front();
    if (o8 !== exp_r) begin
      failures++; $display("FAIL gate_capture: got %h expected %h", o8, exp_r);
    end
    in_valid8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (o8 !== held) begin
        failures++; $display("FAIL gate_hold_%0d: got %h expected %h", i, o8, held);
      end
      if (out_valid8 !== 1'b0) begin
        failures++; $display("FAIL gate_valid_%0d: got %b expected 0", i, out_valid8);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      in_valid8 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      q8.push_back(model(8, a8, b8, cin8));
      tick();
      checks += 2;
      exp_r = q8.pop_front();
      if (o8 !== exp_r) begin
        failures++; $display("FAIL b2b_%0d: got %h expected %h", i, o8, exp_r);
      end
      if (out_valid8 !== 1'b1) begin
        failures++; $display("FAIL b2b_%0d_valid: got %b expected 1", i, out_valid8);
      end
    end
    in_valid8 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 8; i++) begin
      rst = (i == 3 || i == 4);
      in_valid8 = 1'b1; in_valid1 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      if (!rst) begin
        q8.push_back(model(8, a8, b8, cin8));
        q1.push_back(model(1, 8'(a1), 8'(b1), cin1));
      end
      tick();
      if (rst) begin
        checks += 4;
        if (o8 !== res_t'(0)) begin
          failures++; $display("FAIL mid_rst_%0d_w8: got %h expected %h", i, o8, res_t'(0));
        end
        if (out_valid8 !== 1'b0) begin
          failures++; $display("FAIL mid_rst_%0d_w8_valid: got %b expected 0", i, out_valid8);
        end
        if (o1 !== res_t'(0)) begin
          failures++; $display("FAIL mid_rst_%0d_w1: got %h expected %h", i, o1, res_t'(0));
        end
        if (out_valid1 !== 1'b0) begin
          failures++; $display("FAIL mid_rst_%0d_w1_valid: got %b expected 0", i, out_valid1);
        end
      end else begin
        checks += 4;
        exp_r = q8.pop_front();
        if (o8 !== exp_r) begin
          failures++; $display("FAIL mid_%0d_w8: got %h expected %h", i, o8, exp_r);
        end
        if (out_valid8 !== 1'b1) begin
          failures++; $display("FAIL mid_%0d_w8_valid: got %b expected 1", i, out_valid8);
        end
        exp_r = q1.pop_front();
        if (o1 !== exp_r) begin
          failures++; $display("FAIL mid_%0d_w1: got %h expected %h", i, o1, exp_r);
        end
        if (out_valid1 !== 1'b1) begin
          failures++; $display("FAIL mid_%0d_w1_valid: got %b expected 1", i, out_valid1);
        end
      end
    end
    rst = 1'b0;
    in_valid8 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_wrap_ovf();
    test_valid_gating();
    test_back_to_back();
    test_reset_midstream();
    checks += 1;
    if ((q1.size() + q8.size()) != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q1.size() + q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/somador_reg.md
Name: somador_reg

Overview:
- Registered ripple-carry adder computing s/cout = a + b + cin with one cycle of latency.
- WIDTH=1 (the default) is a registered single-bit full adder, the arithmetic primitive of the ADDAC datapath.
- Wider instances serve as generic add stages.
- Adds input/output valid qualification and status flags (zero, signed overflow).

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high, sampled on rising edge of clk.
- in_valid  input  1  qualifies a, b, cin for capture this cycle.
- a  input  WIDTH  operand A (unsigned; two's complement for the ovf flag).
- b  input  WIDTH  operand B.
- cin  input  1  carry in, weight 1 (LSB).
- s  output  WIDTH  registered sum, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry out of MSB.
- out_valid  output  1  s/cout/flags hold a result computed from a captured input.
- zero  output  1  registered; 1 when s == 0.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a rising clk edge): s=0, cout=0, out_valid=0, zero=0, ovf=0. Reset has priority over in_valid in the same cycle. Asserting reset mid-stream discards any pending result.
- Combinational core: bitwise ripple-carry chain of full-adder cells.
  - c[0]=cin
  - s_i = a_i ^ b_i ^ c_i
  - c[i+1] = a_i&b_i | a_i&c_i | b_i&c_i
  - cout = c[WIDTH]
- Capture: on a rising edge with rst=0 and in_valid=1, register s, cout, zero, ovf from current inputs and set out_valid=1. Latency is exactly 1 cycle. Inputs change freely between edges.
- Hold: on a rising edge with rst=0 and in_valid=0:
  - s, cout, zero and ovf keep their previous values.
  - out_valid drops to 0 on that edge.
- Back-to-back: in_valid=1 every cycle gives one result per cycle. There is no stall and no backpressure.
- Arithmetic: {cout,s} == a + b + cin, computed exactly in WIDTH+1 bits. There is no saturation; wrap-around is natural modulo 2^WIDTH, with the wrapped bit in cout.
- WIDTH=1: ovf = c[0]^c[1] = cin^cout. zero = ~s.
- Inputs containing X/Z are not required to produce defined outputs. Outputs must never be X after the first reset.

Test Plan:
- Reset: hold rst=1 two cycles with in_valid=1, a=1, b=1, cin=1 -> s=0, cout=0, out_valid=0, zero=0, ovf=0. Release rst -> first result appears one edge later.
- WIDTH=1 exhaustive truth table. Apply {a,b,cin} = 000,001,010,011,100,101,110,111 on consecutive cycles. Expected {s,cout} one cycle later: 00,10,10,01,10,01,01,11. Check with === on every result.
- WIDTH=8 wrap: a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, zero=1, ovf=0.
- WIDTH=8 signed overflow:
  - a=0x7F, b=0x01, cin=0 -> s=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80, cin=0 -> s=0x00, cout=1, ovf=1, zero=1.
- Valid gating: result 0x05+0x03+1 (s=0x09) captured, then in_valid=0 with a=0xAA, b=0x55 -> s stays 0x09, out_valid=0.
- Reset mid-stream: rst=1 during continuous in_valid=1 traffic -> all outputs 0 next edge. Traffic resumes correctly after release.
